// File: rtl/cic_pkg.sv
// Shared sizing helpers and types for the CIC interpolator and decimator.
// Default widths match the 16-bit, 3-stage, R up to 128 configuration.
package cic_pkg;

    localparam int CIC_DW     = 16;
    localparam int CIC_N      = 3;
    localparam int CIC_OS_MAX = 7;
    localparam int CIC_OS_W   = 3;

    function automatic int iw_calc(input int dw, input int n, input int os_max);
        return dw + n * os_max;
    endfunction

    localparam int CIC_IW = iw_calc(CIC_DW, CIC_N, CIC_OS_MAX);

    typedef logic signed [CIC_IW-1:0] cic_acc_t;

    // Normalising shift: the interpolator gain is R**(N-1).
    function automatic int shift_amt(input int n, input logic [CIC_OS_W-1:0] os);
        return (n - 1) * int'(os);
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One wrapping IW-bit integrator register with synchronous clear.
// Overflow is intentional: the comb/integrator pair is exact modulo 2**W.
module cic_integrator_stage
    import cic_pkg::*;
#(
    parameter int W = CIC_IW
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr_i,
    input  logic signed [W-1:0] din_i,
    output logic signed [W-1:0] acc_o
);

    logic signed [W-1:0] acc_q;
    logic signed [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q + din_i;
        if (clr_i) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cic_interp_filter.sv
// Hogenauer CIC interpolator: low-rate combs, zero-stuffing, full-rate integrators.
// The low rate is a phase counter on the single clock; gain is normalised to unity.
module cic_interp_filter
    import cic_pkg::*;
#(
    parameter int DW     = CIC_DW,
    parameter int N      = CIC_N,
    parameter int OS_MAX = CIC_OS_MAX
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CIC_OS_W-1:0]  os_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    output logic                 underrun
);

    localparam int IW = iw_calc(DW, N, OS_MAX);
    localparam int PW = (OS_MAX > 0) ? OS_MAX : 1;

    typedef logic signed [IW-1:0] acc_t;

    logic [CIC_OS_W-1:0] os_q;
    logic                cfg_q;
    logic                run_q;
    logic                run_d;
    logic [PW-1:0]       phase_q;
    logic [PW-1:0]       phase_d;
    logic [PW-1:0]       phase_mask;
    logic                chg;
    logic                slot;
    logic                accept;

    acc_t                comb_d_q [N];
    acc_t                comb_x   [N];
    acc_t                comb_out;
    acc_t                z_q;
    acc_t                z_d;
    acc_t                integ    [N+1];

    logic [N:0]          vld_q;
    logic [N:0]          vld_d;
    logic                out_valid_q;
    logic                out_valid_d;
    logic signed [DW-1:0] out_q;
    logic signed [DW-1:0] out_d;

    // cfg_q masks the compare until os_q has captured os_sel once after reset.
    always_comb begin
        chg        = cfg_q && (os_sel != os_q);
        slot       = run_q && (phase_q == '0) && !chg;
        accept     = slot && in_valid;
        phase_mask = PW'((32'd1 << os_q) - 32'd1);
        run_d      = !chg;
        phase_d    = '0;
        if (run_q && !chg) begin
            phase_d = (phase_q + PW'(1)) & phase_mask;
        end
    end

    assign in_ready = slot;
    assign underrun = slot && !in_valid;

    // Comb chain: an underrun slot pushes a zero through, like a real sample.
    always_comb begin : comb_chain
        acc_t c;
        c = accept ? acc_t'(in_data) : '0;
        for (int k = 0; k < N; k++) begin
            comb_x[k] = c;
            c         = c - comb_d_q[k];
        end
        comb_out = c;
    end

    always_comb begin
        z_d         = slot ? comb_out : '0;
        vld_d       = chg ? '0 : {vld_q[N-1:0], accept};
        out_valid_d = chg ? 1'b0 : (out_valid_q | vld_q[N]);
        out_d       = chg ? '0 : DW'(integ[N] >>> shift_amt(N, os_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            os_q        <= '0;
            cfg_q       <= 1'b0;
            run_q       <= 1'b0;
            phase_q     <= '0;
            z_q         <= '0;
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int k = 0; k < N; k++) begin
                comb_d_q[k] <= '0;
            end
        end else begin
            os_q        <= os_sel;
            cfg_q       <= 1'b1;
            run_q       <= run_d;
            phase_q     <= phase_d;
            z_q         <= z_d;
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            for (int k = 0; k < N; k++) begin
                if (chg) begin
                    comb_d_q[k] <= '0;
                end else if (slot) begin
                    comb_d_q[k] <= comb_x[k];
                end
            end
        end
    end

    // Integrators run every clock on the zero-stuffed stream.
    assign integ[0] = z_q;

    for (genvar g = 0; g < N; g++) begin : g_integ
        cic_integrator_stage #(
            .W(IW)
        ) u_stage (
            .clk    (clk),
            .reset_n(reset_n),
            .clr_i  (chg),
            .din_i  (integ[g]),
            .acc_o  (integ[g+1])
        );
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_cic_interp_filter.sv
// Bench for cic_interp_filter: reference is a direct convolution of the
// zero-stuffed input with the CIC impulse response, scaled by R**(N-1).
module tb_cic_interp_filter;

    localparam int N = 3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [2:0]         os_sel;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               underrun;

    int cmp_cnt = 0;
    int err_cnt = 0;

    longint hist[$];
    longint h[0:511];
    int     hlen;
    int     cur_os;
    int     rr;
    int     first_acc;

    logic               e_rdy;
    logic               o_rdy;
    logic               o_und;
    logic               e_vld;
    logic signed [15:0] e_out;

    always #5 clk = ~clk;

    cic_interp_filter #(
        .DW(16),
        .N(N),
        .OS_MAX(7)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .os_sel   (os_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .underrun (underrun)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Impulse response of ((1 - z^-R)/(1 - z^-1))^N: N boxcars of length R convolved.
    task automatic set_model(input int os);
        longint t[0:511];
        cur_os    = os;
        rr        = 1 << os;
        first_acc = -1;
        hist.delete();
        for (int i = 0; i < 512; i++) h[i] = 0;
        h[0] = 1;
        hlen = 1;
        repeat (N) begin
            for (int i = 0; i < 512; i++) t[i] = 0;
            for (int i = 0; i < hlen; i++)
                for (int j = 0; j < rr; j++) t[i+j] += h[i];
            hlen += rr - 1;
            for (int i = 0; i < hlen; i++) h[i] = t[i];
        end
    endtask

    function automatic logic signed [15:0] model_out(input int j);
        longint acc;
        longint s;
        acc = 0;
        if (j >= 0)
            for (int k = 0; k < hlen && k <= j; k++) acc += h[k] * hist[j-k];
        s = acc >>> ((N - 1) * cur_os);
        return s[15:0];
    endfunction

    // One clock: inputs set at negedge, outputs settled at posedge+1.
    task automatic tick(input logic v, input logic signed [15:0] d);
        int k;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        #1;
        k     = hist.size();
        e_rdy = (k >= 1) && (((k - 1) % rr) == 0);
        o_rdy = in_ready;
        o_und = underrun;
        hist.push_back((e_rdy && v) ? longint'(d) : 64'sd0);
        if (e_rdy && v && first_acc < 0) first_acc = k;
        @(posedge clk);
        #1;
        e_out = model_out(k - N - 1);
        e_vld = (first_acc >= 0) && (k - N - 1 >= first_acc);
    endtask

    task automatic do_reset(input logic [2:0] os);
        reset_n  = 1'b0;
        os_sel   = os;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        set_model(int'(os));
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        os_sel   = 3'd1;
        in_valid = 1'b1;
        in_data  = 16'sd100;
        repeat (3) @(posedge clk);
        #2;
        cmp_cnt++; if (out_data !== 16'sd0) begin err_cnt++; $display("FAIL rst_out_data got %0d want 0", out_data); end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        cmp_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL rst_underrun got %b want 0", underrun); end
        reset_n = 1'b1;
        set_model(1);
        tick(1'b1, 16'sd100);
        cmp_cnt++; if (o_rdy !== 1'b0) begin err_cnt++; $display("FAIL rst_idle_cycle in_ready got %b want 0", o_rdy); end
        tick(1'b1, 16'sd100);
        cmp_cnt++; if (o_rdy !== 1'b1) begin err_cnt++; $display("FAIL rst_first_slot in_ready got %b want 1", o_rdy); end
    endtask

    task automatic test_impulse();
        int imp[4] = '{256, 768, 768, 256};
        do_reset(3'd1);
        for (int i = 0; i < 14; i++) begin
            tick(1'b1, (i == 1) ? 16'sd1024 : 16'sd0);
            cmp_cnt++; if (o_rdy !== e_rdy) begin err_cnt++; $display("FAIL imp_ready k=%0d got %b want %b", i, o_rdy, e_rdy); end
            cmp_cnt++; if (out_data !== e_out) begin err_cnt++; $display("FAIL imp_model k=%0d got %0d want %0d", i, out_data, e_out); end
            cmp_cnt++; if (out_valid !== e_vld) begin err_cnt++; $display("FAIL imp_valid k=%0d got %b want %b", i, out_valid, e_vld); end
            if (i >= 5 && i <= 8) begin
                cmp_cnt++;
                if (out_data !== 16'(imp[i-5])) begin err_cnt++; $display("FAIL imp_table k=%0d got %0d want %0d", i, out_data, imp[i-5]); end
            end
            if (i >= 9) begin
                cmp_cnt++;
                if (out_data !== 16'sd0) begin err_cnt++; $display("FAIL imp_tail k=%0d got %0d want 0", i, out_data); end
            end
        end
    endtask

    task automatic test_dc_step();
        do_reset(3'd3);
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 16'sd1000);
            cmp_cnt++; if (out_data !== e_out) begin err_cnt++; $display("FAIL dc_pos_model k=%0d got %0d want %0d", i, out_data, e_out); end
            cmp_cnt++; if (out_valid !== e_vld) begin err_cnt++; $display("FAIL dc_pos_valid k=%0d got %b want %b", i, out_valid, e_vld); end
            if (i >= 40) begin
                cmp_cnt++;
                if (out_data !== 16'sd1000) begin err_cnt++; $display("FAIL dc_pos_settle k=%0d got %0d want 1000", i, out_data); end
            end
        end
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, -16'sd1000);
            cmp_cnt++; if (out_data !== e_out) begin err_cnt++; $display("FAIL dc_neg_model k=%0d got %0d want %0d", i, out_data, e_out); end
            if (i >= 40) begin
                cmp_cnt++;
                if (out_data !== -16'sd1000) begin err_cnt++; $display("FAIL dc_neg_settle k=%0d got %0d want -1000", i, out_data); end
            end
        end
    endtask

    task automatic test_passthrough();
        do_reset(3'd0);
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 16'(i * 37 - 500));
            if (i >= 1) begin
                cmp_cnt++;
                if (o_rdy !== 1'b1) begin err_cnt++; $display("FAIL pass_ready k=%0d got %b want 1", i, o_rdy); end
            end
            cmp_cnt++; if (o_und !== 1'b0) begin err_cnt++; $display("FAIL pass_underrun k=%0d got %b want 0", i, o_und); end
            cmp_cnt++; if (out_data !== e_out) begin err_cnt++; $display("FAIL pass_model k=%0d got %0d want %0d", i, out_data, e_out); end
            if (i >= 5) begin
                cmp_cnt++;
                if (out_data !== 16'((i - 4) * 37 - 500)) begin
                    err_cnt++;
                    $display("FAIL pass_delay k=%0d got %0d want %0d", i, out_data, (i - 4) * 37 - 500);
                end
            end
        end
    endtask

    task automatic test_underrun();
        int pulses = 0;
        logic v;
        do_reset(3'd2);
        for (int i = 0; i < 41; i++) begin
            v = (i != 9);
            tick(v, 16'($urandom_range(0, 65535)));
            if (o_und === 1'b1) pulses++;
            cmp_cnt++; if (o_rdy !== e_rdy) begin err_cnt++; $display("FAIL und_ready k=%0d got %b want %b", i, o_rdy, e_rdy); end
            cmp_cnt++; if (o_und !== (e_rdy && !v)) begin err_cnt++; $display("FAIL und_pulse k=%0d got %b want %b", i, o_und, e_rdy && !v); end
            cmp_cnt++; if (out_data !== e_out) begin err_cnt++; $display("FAIL und_model k=%0d got %0d want %0d", i, out_data, e_out); end
        end
        cmp_cnt++; if (pulses != 1) begin err_cnt++; $display("FAIL und_count got %0d want 1", pulses); end
    endtask

    task automatic test_fullscale();
        logic signed [15:0] d;
        int k0;
        do_reset(3'd7);
        for (int i = 0; i < 1 + 128 * 12; i++) begin
            k0 = hist.size();
            d  = ((((k0 - 1) / 128) % 2) == 0) ? 16'h7FFF : 16'h8000;
            tick(1'b1, d);
            cmp_cnt++; if ($isunknown(out_data)) begin err_cnt++; $display("FAIL fs_xcheck k=%0d got %h want known", i, out_data); end
            cmp_cnt++; if (out_data !== e_out) begin err_cnt++; $display("FAIL fs_model k=%0d got %0d want %0d", i, out_data, e_out); end
        end
    endtask

    task automatic test_os_change();
        do_reset(3'd2);
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 16'($urandom_range(0, 65535)));
            cmp_cnt++; if (out_data !== e_out) begin err_cnt++; $display("FAIL osc_pre_model k=%0d got %0d want %0d", i, out_data, e_out); end
        end
        @(negedge clk);
        os_sel   = 3'd3;
        in_valid = 1'b1;
        in_data  = 16'sd5;
        #1;
        cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL osc_ready got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL osc_valid_drop got %b want 0", out_valid); end
        cmp_cnt++; if (out_data !== 16'sd0) begin err_cnt++; $display("FAIL osc_clear got %0d want 0", out_data); end
        set_model(3);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, (i == 1) ? 16'sd1024 : 16'sd0);
            cmp_cnt++; if (o_rdy !== e_rdy) begin err_cnt++; $display("FAIL osc_post_ready k=%0d got %b want %b", i, o_rdy, e_rdy); end
            cmp_cnt++; if (out_data !== e_out) begin err_cnt++; $display("FAIL osc_post_model k=%0d got %0d want %0d", i, out_data, e_out); end
            cmp_cnt++; if (out_valid !== e_vld) begin err_cnt++; $display("FAIL osc_post_valid k=%0d got %b want %b", i, out_valid, e_vld); end
            if (i == 5) begin
                cmp_cnt++;
                if (out_data !== 16'sd16) begin err_cnt++; $display("FAIL osc_first_out got %0d want 16", out_data); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(3'd1);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 16'($urandom_range(0, 65535)));
            cmp_cnt++; if (out_data !== e_out) begin err_cnt++; $display("FAIL rmid_pre_model k=%0d got %0d want %0d", i, out_data, e_out); end
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        cmp_cnt++; if (out_data !== 16'sd0) begin err_cnt++; $display("FAIL rmid_out_data got %0d want 0", out_data); end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
        cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL rmid_in_ready got %b want 0", in_ready); end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        set_model(1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, (i == 1) ? 16'sd1024 : 16'sd0);
            cmp_cnt++; if (out_data !== e_out) begin err_cnt++; $display("FAIL rmid_post_model k=%0d got %0d want %0d", i, out_data, e_out); end
            cmp_cnt++; if (out_valid !== e_vld) begin err_cnt++; $display("FAIL rmid_post_valid k=%0d got %b want %b", i, out_valid, e_vld); end
            if (i == 5) begin
                cmp_cnt++;
                if (out_data !== 16'sd256) begin err_cnt++; $display("FAIL rmid_first_out got %0d want 256", out_data); end
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        os_sel   = 3'd0;
        in_valid = 1'b0;
        in_data  = '0;
        rr       = 1;
        cur_os   = 0;
        hlen     = 1;
        first_acc = -1;
        test_reset();
        test_impulse();
        test_dc_step();
        test_passthrough();
        test_underrun();
        test_fullscale();
        test_os_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
